// File: rtl/timer_pkg.sv
// Shared timer definitions: default data width and the packed layout of a
// capture FIFO entry, which is {data, delta, first, alarm} from MSB to LSB.
package timer_pkg;

    localparam int DEFAULT_DATA_W = 32;

    localparam int ALARM_OFF = 0;
    localparam int FIRST_OFF = 1;
    localparam int DELTA_OFF = 2;

    function automatic int data_off(input int data_w);
        return DELTA_OFF + data_w;
    endfunction

    function automatic int entry_w(input int data_w);
        return 2 * data_w + 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extended pointers; level is the pointer difference.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_an_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [WIDTH-1:0]  data_i,
    output logic [WIDTH-1:0]  data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o
);

    localparam logic [ADDR_W:0] FULL_LEVEL = DEPTH[ADDR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        level_o = wr_ptr - rd_ptr;
        empty_o = (level_o == '0);
        full_o  = (level_o == FULL_LEVEL);
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        // Head reads as zero when empty so nothing stale or unknown escapes.
        data_o  = empty_o ? '0 : mem[rd_ptr[ADDR_W-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/capture_delta_fifo.sv
// Buffers captured counter values tagged with delta-since-previous-capture,
// a first-capture flag and an alarm-seen flag, presented on a valid/ready stream.
module capture_delta_fifo
    import timer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_an_i,
    input  logic              capture_stb_i,
    input  logic [DATA_W-1:0] captured_i,
    input  logic              rst_capture_stb_i,
    input  logic              alarm_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [DATA_W-1:0] m_delta_o,
    output logic              m_first_o,
    output logic              m_alarm_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o,
    input  logic              clr_overflow_i
);

    localparam int ENTRY_W  = entry_w(DATA_W);
    localparam int DATA_OFF = data_off(DATA_W);

    logic [DATA_W-1:0]  last_q;
    logic               have_ref_q;
    logic               alarm_seen_q;
    logic               alarm_prev_q;
    logic               overflow_q;

    logic               rise;
    logic               first;
    logic               alarm_bit;
    logic [DATA_W-1:0]  delta;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push;
    logic               drop;
    logic [ENTRY_W-1:0] entry;
    logic [ENTRY_W-1:0] head;

    // Stream handshake: an entry transfers on every rising edge where
    // m_valid_o and m_ready_i are both high; while m_valid_o is high and
    // m_ready_i is low the head fields hold. m_valid_o never depends on m_ready_i.
    always_comb begin
        rise      = alarm_i & ~alarm_prev_q;
        first     = ~have_ref_q | rst_capture_stb_i;
        delta     = first ? captured_i : captured_i - last_q;
        alarm_bit = ~rst_capture_stb_i & (alarm_seen_q | rise);
        pop       = ~empty & m_ready_i;
        push      = capture_stb_i & (~full | pop);
        drop      = capture_stb_i & ~push;

        entry                          = '0;
        entry[DATA_OFF +: DATA_W]      = captured_i;
        entry[DELTA_OFF +: DATA_W]     = delta;
        entry[FIRST_OFF]               = first;
        entry[ALARM_OFF]               = alarm_bit;
    end

    sync_fifo #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_an_i (rst_an_i),
        .push_i   (push),
        .pop_i    (pop),
        .data_i   (entry),
        .data_o   (head),
        .full_o   (full),
        .empty_o  (empty),
        .level_o  (level_o)
    );

    // Dropped captures still advance the reference and clear the alarm flag.
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            last_q       <= '0;
            have_ref_q   <= 1'b0;
            alarm_seen_q <= 1'b0;
            alarm_prev_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            alarm_prev_q <= alarm_i;
            if (capture_stb_i) begin
                last_q       <= captured_i;
                have_ref_q   <= 1'b1;
                alarm_seen_q <= 1'b0;
            end else if (rst_capture_stb_i) begin
                have_ref_q   <= 1'b0;
                alarm_seen_q <= 1'b0;
            end else if (rise) begin
                alarm_seen_q <= 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_comb begin
        m_valid_o  = ~empty;
        m_data_o   = head[DATA_OFF +: DATA_W];
        m_delta_o  = head[DELTA_OFF +: DATA_W];
        m_first_o  = head[FIRST_OFF];
        m_alarm_o  = head[ALARM_OFF];
        overflow_o = overflow_q;
    end

endmodule

// File: tb/tb_capture_delta_fifo.sv
// Bench for capture_delta_fifo: directed scenarios plus a randomized run
// against a queue-based reference model of the capture/delta/alarm rules.
module tb_capture_delta_fifo;

    localparam int W = 32;
    localparam int D = 8;
    localparam int E = 2 * W + 2;

    logic         clk = 1'b0;
    logic         rst_an_i = 1'b0;
    logic         capture_stb_i = 1'b0;
    logic [W-1:0] captured_i = '0;
    logic         rst_capture_stb_i = 1'b0;
    logic         alarm_i = 1'b0;
    logic         m_valid_o;
    logic         m_ready_i = 1'b0;
    logic [W-1:0] m_data_o;
    logic [W-1:0] m_delta_o;
    logic         m_first_o;
    logic         m_alarm_o;
    logic [3:0]   level_o;
    logic         overflow_o;
    logic         clr_overflow_i = 1'b0;
    logic [E-1:0] head;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [E-1:0] exp_q[$];
    logic [W-1:0] mdl_last;
    logic         mdl_have_ref;
    logic         mdl_seen;
    logic         mdl_alarm_prev;
    logic         mdl_ovf;

    capture_delta_fifo dut (
        .clk_i             (clk),
        .rst_an_i          (rst_an_i),
        .capture_stb_i     (capture_stb_i),
        .captured_i        (captured_i),
        .rst_capture_stb_i (rst_capture_stb_i),
        .alarm_i           (alarm_i),
        .m_valid_o         (m_valid_o),
        .m_ready_i         (m_ready_i),
        .m_data_o          (m_data_o),
        .m_delta_o         (m_delta_o),
        .m_first_o         (m_first_o),
        .m_alarm_o         (m_alarm_o),
        .level_o           (level_o),
        .overflow_o        (overflow_o),
        .clr_overflow_i    (clr_overflow_i)
    );

    always #5 clk = ~clk;

    assign head = {m_data_o, m_delta_o, m_first_o, m_alarm_o};

    function automatic logic [E-1:0] ent(input logic [W-1:0] d, input logic [W-1:0] dl,
                                         input logic f, input logic a);
        return {d, dl, f, a};
    endfunction

    task automatic model_clear();
        exp_q.delete();
        mdl_last       = '0;
        mdl_have_ref   = 1'b0;
        mdl_seen       = 1'b0;
        mdl_alarm_prev = 1'b0;
        mdl_ovf        = 1'b0;
    endtask

    // One clock: evaluate the model on pre-edge inputs, advance to #1 after
    // the edge, commit the model, then drop the one-cycle pulses.
    task automatic tick();
        logic         pop, rise, first, al, push, drop, cap, rcs, clr, alm;
        logic [W-1:0] dl, cd;
        cap   = capture_stb_i;
        rcs   = rst_capture_stb_i;
        clr   = clr_overflow_i;
        alm   = alarm_i;
        cd    = captured_i;
        pop   = (exp_q.size() != 0) && m_ready_i;
        rise  = alm && !mdl_alarm_prev;
        first = !mdl_have_ref || rcs;
        dl    = first ? cd : cd - mdl_last;
        al    = !rcs && (mdl_seen || rise);
        push  = cap && (exp_q.size() < D || pop);
        drop  = cap && !push;
        @(posedge clk);
        #1;
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back({cd, dl, first, al});
        if (drop) mdl_ovf = 1'b1;
        else if (clr) mdl_ovf = 1'b0;
        if (cap) begin
            mdl_last = cd; mdl_have_ref = 1'b1; mdl_seen = 1'b0;
        end else if (rcs) begin
            mdl_have_ref = 1'b0; mdl_seen = 1'b0;
        end else if (rise) begin
            mdl_seen = 1'b1;
        end
        mdl_alarm_prev = alm;
        capture_stb_i     = 1'b0;
        rst_capture_stb_i = 1'b0;
        clr_overflow_i    = 1'b0;
    endtask

    task automatic cap(input logic [W-1:0] v);
        capture_stb_i = 1'b1;
        captured_i    = v;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        capture_stb_i = 0; rst_capture_stb_i = 0; clr_overflow_i = 0;
        alarm_i = 0; m_ready_i = 0;
        rst_an_i = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_an_i = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if ({m_valid_o, head, level_o, overflow_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_during: valid=%b head=%h level=%0d ovf=%b, want all 0",
                     m_valid_o, head, level_o, overflow_o);
        end
        do_reset();
        idle(1);
        tests_run++;
        if ({m_valid_o, head, level_o, overflow_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_after: valid=%b head=%h level=%0d ovf=%b, want all 0",
                     m_valid_o, head, level_o, overflow_o);
        end
    endtask

    task automatic test_basic();
        do_reset();
        m_ready_i = 1'b1;
        cap(100);
        tests_run++;
        if (m_valid_o !== 1'b1 || head !== ent(100, 100, 1, 0)) begin
            tests_failed++;
            $display("FAIL basic_100: valid=%b head=%h want %h", m_valid_o, head, ent(100, 100, 1, 0));
        end
        cap(250);
        tests_run++;
        if (head !== ent(250, 150, 0, 0)) begin
            tests_failed++;
            $display("FAIL basic_250: got %h want %h", head, ent(250, 150, 0, 0));
        end
        cap(32'hFFFF_FFF0);
        cap(32'h0000_0010);
        tests_run++;
        if (head !== ent(32'h10, 32'h20, 0, 0)) begin
            tests_failed++;
            $display("FAIL basic_wrap: got %h want %h", head, ent(32'h10, 32'h20, 0, 0));
        end
        idle(1);
        tests_run++;
        if (m_valid_o !== 1'b0 || level_o !== 4'd0) begin
            tests_failed++;
            $display("FAIL basic_drained: valid=%b level=%0d want 0/0", m_valid_o, level_o);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) cap(32'(1000 + 7 * i));
        tests_run++;
        if (level_o !== 4'd8 || overflow_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_level_ovf: level=%0d ovf=%b want 8/1", level_o, overflow_o);
        end
        m_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (head !== ent(32'(1000 + 7 * i), (i == 0) ? 32'd1000 : 32'd7, i == 0, 1'b0)) begin
                tests_failed++;
                $display("FAIL drain_%0d: got %h want %h", i, head,
                         ent(32'(1000 + 7 * i), (i == 0) ? 32'd1000 : 32'd7, i == 0, 1'b0));
            end
            tick();
        end
        tests_run++;
        if (level_o !== 4'd0) begin
            tests_failed++;
            $display("FAIL drain_empty: level=%0d want 0", level_o);
        end
        cap(2000);
        tests_run++;
        if (head !== ent(2000, 944, 0, 0) || overflow_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL after_drop: head=%h ovf=%b want %h/1", head, overflow_o, ent(2000, 944, 0, 0));
        end
        clr_overflow_i = 1'b1;
        tick();
        tests_run++;
        if (overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clear: ovf=%b want 0", overflow_o);
        end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        for (int i = 0; i < 8; i++) cap(32'(5 + 3 * i));
        m_ready_i = 1'b1;
        cap(99);
        tests_run++;
        if (level_o !== 4'd8 || overflow_o !== 1'b0 || head !== ent(8, 3, 0, 0)) begin
            tests_failed++;
            $display("FAIL full_push_pop: level=%0d ovf=%b head=%h want 8/0/%h",
                     level_o, overflow_o, head, ent(8, 3, 0, 0));
        end
        m_ready_i = 1'b0;
    endtask

    task automatic test_reset_capture();
        do_reset();
        m_ready_i = 1'b1;
        cap(500);
        rst_capture_stb_i = 1'b1;
        tick();
        cap(30);
        tests_run++;
        if (head !== ent(30, 30, 1, 0)) begin
            tests_failed++;
            $display("FAIL rst_cap_separate: got %h want %h", head, ent(30, 30, 1, 0));
        end
        cap(35);
        alarm_i = 1'b1;
        rst_capture_stb_i = 1'b1;
        cap(40);
        tests_run++;
        if (head !== ent(40, 40, 1, 0)) begin
            tests_failed++;
            $display("FAIL rst_cap_coincident: got %h want %h", head, ent(40, 40, 1, 0));
        end
        alarm_i = 1'b0;
        tick();
    endtask

    task automatic test_alarm();
        do_reset();
        m_ready_i = 1'b1;
        cap(10);
        idle(2);
        alarm_i = 1'b1;
        tick();
        cap(20);
        tests_run++;
        if (head !== ent(20, 10, 0, 1)) begin
            tests_failed++;
            $display("FAIL alarm_seen: got %h want %h", head, ent(20, 10, 0, 1));
        end
        cap(30);
        tests_run++;
        if (head !== ent(30, 10, 0, 0)) begin
            tests_failed++;
            $display("FAIL alarm_held: got %h want %h", head, ent(30, 10, 0, 0));
        end
        alarm_i = 1'b0;
        tick();
        alarm_i = 1'b1;
        cap(40);
        tests_run++;
        if (head !== ent(40, 10, 0, 1)) begin
            tests_failed++;
            $display("FAIL alarm_same_cycle: got %h want %h", head, ent(40, 10, 0, 1));
        end
        alarm_i = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) cap(32'(60 + i));
        tests_run++;
        if (level_o !== 4'd5) begin
            tests_failed++;
            $display("FAIL mid_level5: level=%0d want 5", level_o);
        end
        #2;
        rst_an_i = 1'b0;
        model_clear();
        #1;
        tests_run++;
        if ({m_valid_o, head, level_o, overflow_o} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_async: valid=%b head=%h level=%0d ovf=%b want all 0",
                     m_valid_o, head, level_o, overflow_o);
        end
        @(posedge clk);
        #1;
        rst_an_i = 1'b1;
        m_ready_i = 1'b1;
        cap(77);
        tests_run++;
        if (head !== ent(77, 77, 1, 0)) begin
            tests_failed++;
            $display("FAIL mid_reset_first: got %h want %h", head, ent(77, 77, 1, 0));
        end
        m_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) cap(32'(80 + i));
        clr_overflow_i = 1'b1;
        cap(200);
        tests_run++;
        if (overflow_o !== 1'b1 || level_o !== 4'd8) begin
            tests_failed++;
            $display("FAIL set_beats_clear: ovf=%b level=%0d want 1/8", overflow_o, level_o);
        end
        clr_overflow_i = 1'b1;
        tick();
        tests_run++;
        if (overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_alone: ovf=%b want 0", overflow_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            capture_stb_i     = ($urandom_range(0, 3) != 0);
            captured_i        = $urandom;
            rst_capture_stb_i = ($urandom_range(0, 15) == 0);
            clr_overflow_i    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 4) == 0) alarm_i = ~alarm_i;
            m_ready_i = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick();
            tests_run++;
            if (level_o !== 4'(exp_q.size()) || m_valid_o !== (exp_q.size() != 0)) begin
                tests_failed++;
                $display("FAIL rand_level[%0d]: level=%0d valid=%b want %0d", i, level_o,
                         m_valid_o, exp_q.size());
            end
            tests_run++;
            if (overflow_o !== mdl_ovf) begin
                tests_failed++;
                $display("FAIL rand_ovf[%0d]: ovf=%b want %b", i, overflow_o, mdl_ovf);
            end
            if (exp_q.size() != 0) begin
                tests_run++;
                if (head !== exp_q[0]) begin
                    tests_failed++;
                    $display("FAIL rand_head[%0d]: got %h want %h", i, head, exp_q[0]);
                end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_fill_overflow();
        test_push_pop_full();
        test_reset_capture();
        test_alarm();
        test_mid_reset_overflow();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
